// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of one sprite ROM read port with tagged responses
// Optional burst lock on the grant when SPRITE_ARB_LOCK_EN is defined.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk_i,
  input  logic                      reset_n_i,
  input  logic                      hold_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
`ifdef SPRITE_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock_i,
`endif
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [ADDR_W-1:0]         rom_address_o,
  input  logic [DATA_W-1:0]         rom_q_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [N_REQ-1:0]  tag_q [ROM_LAT];

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;

`ifdef SPRITE_ARB_LOCK_EN
  logic              lock_q;
  logic [PTR_W-1:0]  lock_idx_q;
`endif

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      idx = PTR_W'(sum);
      if (!grant_any && req_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
`ifdef SPRITE_ARB_LOCK_EN
    // A live lock overrides the scan; a dropped req_valid falls straight back to RR.
    if (lock_q && req_valid_i[lock_idx_q]) begin
      grant_any = 1'b1;
      grant_idx = lock_idx_q;
    end
`endif
    if (hold_i || !reset_n_i) grant_any = 1'b0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (grant_any) begin
      ptr_d      = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      rom_addr_d = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge vga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q       <= '0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
`ifdef SPRITE_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      tag_q[0]   <= grant;
      for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid_q <= tag_q[ROM_LAT-1];
      if (|tag_q[ROM_LAT-1]) rsp_data_q <= rom_q_i;
`ifdef SPRITE_ARB_LOCK_EN
      if (grant_any) begin
        lock_q     <= req_lock_i[grant_idx];
        lock_idx_q <= grant_idx;
      end else if (lock_q && !req_valid_i[lock_idx_q]) begin
        lock_q     <= 1'b0;
      end
`endif
    end
  end

  assign req_ready_o   = grant;
  assign rom_address_o = rom_addr_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed vector bench for sprite_rom_arbiter
// Lock sequence is built only when SPRITE_ARB_LOCK_EN is defined.
module tb_sprite_rom_arbiter;

  typedef struct packed {
    logic        hold;
    logic [3:0]  valid;
    logic [35:0] addr;
    logic [3:0]  e_ready;
    logic [8:0]  e_rom;
    logic [3:0]  e_rspv;
    logic [4:0]  e_rspd;
  } vec_t;

  localparam logic [35:0] AS = {9'd40, 9'd30, 9'd20, 9'd10};
  localparam logic [35:0] BS = {9'd40, 9'h1FF, 9'd20, 9'd10};

  logic        clk;
  logic        reset_n;
  logic        hold;
  logic [3:0]  req_valid;
  logic [35:0] req_addr;
  logic [3:0]  req_ready;
  logic [8:0]  rom_address;
  logic [4:0]  rom_q = '0;
  logic [3:0]  rsp_valid;
  logic [4:0]  rsp_data;
`ifdef SPRITE_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl [32];

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(9), .DATA_W(5), .ROM_LAT(1)) dut (
    .vga_clk_i     (clk),
    .reset_n_i     (reset_n),
    .hold_i        (hold),
    .req_valid_i   (req_valid),
    .req_addr_i    (req_addr),
`ifdef SPRITE_ARB_LOCK_EN
    .req_lock_i    (req_lock),
`endif
    .req_ready_o   (req_ready),
    .rom_address_o (rom_address),
    .rom_q_i       (rom_q),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Negedge-read ROM whose word is the low five address bits
  always @(negedge clk) rom_q <= rom_address[4:0];

  function automatic vec_t mk(input logic h, input logic [3:0] v, input logic [35:0] a,
                              input logic [3:0] er, input logic [8:0] ea,
                              input logic [3:0] ev, input logic [4:0] ed);
    vec_t r;
    r.hold = h; r.valid = v; r.addr = a;
    r.e_ready = er; r.e_rom = ea; r.e_rspv = ev; r.e_rspd = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic [3:0] v, input logic [35:0] a);
    @(negedge clk);
    hold = h;
    req_valid = v;
    req_addr = a;
    #1;
  endtask

  task automatic chk_outs(input string tag, input int idx, input logic [3:0] er,
                          input logic [8:0] ea, input logic [3:0] ev, input logic [4:0] ed);
    chk({tag, ".ready"}, idx, 32'(req_ready), 32'(er));
    chk({tag, ".rom"},   idx, 32'(rom_address), 32'(ea));
    chk({tag, ".rspv"},  idx, 32'(rsp_valid), 32'(ev));
    chk({tag, ".rspd"},  idx, 32'(rsp_data), 32'(ed));
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 4'hF, AS, 4'h1, 9'd0,   4'h0, 5'd0);
    tbl[1]  = mk(1'b0, 4'hF, AS, 4'h2, 9'd10,  4'h0, 5'd0);
    tbl[2]  = mk(1'b0, 4'hF, AS, 4'h4, 9'd20,  4'h1, 5'd10);
    tbl[3]  = mk(1'b0, 4'hF, AS, 4'h8, 9'd30,  4'h2, 5'd20);
    tbl[4]  = mk(1'b0, 4'hF, AS, 4'h1, 9'd40,  4'h4, 5'd30);
    tbl[5]  = mk(1'b0, 4'hF, AS, 4'h2, 9'd10,  4'h8, 5'd8);
    tbl[6]  = mk(1'b0, 4'hF, AS, 4'h4, 9'd20,  4'h1, 5'd10);
    tbl[7]  = mk(1'b0, 4'hF, AS, 4'h8, 9'd30,  4'h2, 5'd20);
    tbl[8]  = mk(1'b0, 4'h0, AS, 4'h0, 9'd40,  4'h4, 5'd30);
    tbl[9]  = mk(1'b0, 4'h0, AS, 4'h0, 9'd40,  4'h8, 5'd8);
    tbl[10] = mk(1'b0, 4'h0, AS, 4'h0, 9'd40,  4'h0, 5'd8);
    tbl[11] = mk(1'b0, 4'h4, BS, 4'h4, 9'd40,  4'h0, 5'd8);
    tbl[12] = mk(1'b0, 4'h4, BS, 4'h4, 9'h1FF, 4'h0, 5'd8);
    tbl[13] = mk(1'b0, 4'h4, BS, 4'h4, 9'h1FF, 4'h4, 5'h1F);
    tbl[14] = mk(1'b0, 4'h0, BS, 4'h0, 9'h1FF, 4'h4, 5'h1F);
    tbl[15] = mk(1'b0, 4'h0, BS, 4'h0, 9'h1FF, 4'h4, 5'h1F);
    tbl[16] = mk(1'b0, 4'h0, BS, 4'h0, 9'h1FF, 4'h0, 5'h1F);
    tbl[17] = mk(1'b0, 4'hF, AS, 4'h8, 9'h1FF, 4'h0, 5'h1F);
    tbl[18] = mk(1'b0, 4'hF, AS, 4'h1, 9'd40,  4'h0, 5'h1F);
    tbl[19] = mk(1'b1, 4'hF, AS, 4'h0, 9'd10,  4'h8, 5'd8);
    tbl[20] = mk(1'b1, 4'hF, AS, 4'h0, 9'd10,  4'h1, 5'd10);
    tbl[21] = mk(1'b1, 4'hF, AS, 4'h0, 9'd10,  4'h0, 5'd10);
    tbl[22] = mk(1'b0, 4'hF, AS, 4'h2, 9'd10,  4'h0, 5'd10);
    tbl[23] = mk(1'b0, 4'hF, AS, 4'h4, 9'd20,  4'h0, 5'd10);
    tbl[24] = mk(1'b0, 4'h0, AS, 4'h0, 9'd30,  4'h2, 5'd20);
    tbl[25] = mk(1'b0, 4'h0, AS, 4'h0, 9'd30,  4'h4, 5'd30);
    tbl[26] = mk(1'b0, 4'h0, AS, 4'h0, 9'd30,  4'h0, 5'd30);
    tbl[27] = mk(1'b0, 4'h5, AS, 4'h1, 9'd30,  4'h0, 5'd30);
    tbl[28] = mk(1'b0, 4'h5, AS, 4'h4, 9'd10,  4'h0, 5'd30);
    tbl[29] = mk(1'b0, 4'h0, AS, 4'h0, 9'd30,  4'h1, 5'd10);
    tbl[30] = mk(1'b0, 4'h0, AS, 4'h0, 9'd30,  4'h4, 5'd30);
    tbl[31] = mk(1'b0, 4'h0, AS, 4'h0, 9'd30,  4'h0, 5'd30);

    reset_n = 1'b0;
    hold = 1'b0;
    req_valid = 4'hF;
    req_addr = AS;
`ifdef SPRITE_ARB_LOCK_EN
    req_lock = 4'h0;
`endif

    // Reset held with every requester valid
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk_outs("rst", c, 4'h0, 9'd0, 4'h0, 5'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 4'h0;

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].hold, tbl[i].valid, tbl[i].addr);
      chk_outs("vec", i, tbl[i].e_ready, tbl[i].e_rom, tbl[i].e_rspv, tbl[i].e_rspd);
    end

    // Mid-flight reset: transfer from requester 3, then async reset before its response
    step(1'b0, 4'hF, AS);
    chk("mid.ready", 0, 32'(req_ready), 32'h8);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_outs("mid.async", 0, 4'h0, 9'd0, 4'h0, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("mid.norsp", c, 32'(rsp_valid), 32'h0);
    end
    step(1'b0, 4'hF, AS);
    chk("mid.first", 0, 32'(req_ready), 32'h1);

`ifdef SPRITE_ARB_LOCK_EN
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_lock = (c < 4) ? 4'h2 : 4'h0;
      #1;
      chk("lock.hold", c, 32'(req_ready), 32'h2);
    end
    @(negedge clk);
    req_lock = 4'h0;
    #1;
    chk("lock.after", 0, 32'(req_ready), 32'h4);
    @(negedge clk); #1;
    chk("lock.after", 1, 32'(req_ready), 32'h8);
    @(negedge clk); #1;
    chk("lock.after", 2, 32'(req_ready), 32'h1);
`endif

    @(negedge clk);
    req_valid = 4'h0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one sprite ROM read port (address out, q in) among N_REQ pixel requesters, e.g. Pac-Man, four ghosts and the maze/pellet layer, using round-robin arbitration.
- Uses a valid/ready request handshake and returns a tagged response after a fixed ROM latency.
- Sits between the per-sprite draw units and the shared sprite ROM. The palette lookup stays downstream of rsp_data.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 9, ROM address width
DATA_W, 5, ROM word (palette index) width
ROM_LAT, 1, vga_clk posedges from rom_address update to the posedge at which rom_q is valid (negedge-read ROM = 1)

Ports:
vga_clk  in  1  pixel clock; all state on posedge
reset_n  in  1  asynchronous, active-low reset
hold  in  1  1 = issue no new grants (requests stay pending)
req_valid  in  N_REQ  per-requester read request
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i in bits [i*ADDR_W +: ADDR_W]
req_ready  out  N_REQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i] at a posedge
rom_address  out  ADDR_W  registered address to the sprite ROM
rom_q  in  DATA_W  ROM read data
rsp_valid  out  N_REQ  one-hot: response for requester i
rsp_data  out  DATA_W  registered ROM word

Behaviour:
- Reset (async assert, sync-safe release): req_ready=0, rom_address=0, rsp_valid=0, rsp_data=0, RR pointer=0, tag pipeline cleared, lock cleared.
- Grant is combinational from req_valid, the RR pointer, hold and the lock state.
  - Scan order starts at the pointer and wraps: ptr, ptr+1, …, N_REQ-1, 0, …
  - The first valid requester found gets req_ready.
  - At most one bit of req_ready is set; req_ready is 0 when hold=1 or no requester is valid.
  - req_ready[i] never asserts without req_valid[i].
- On a transfer at posedge t:
  - rom_address <= req_addr[i].
  - The pointer moves to (i+1) mod N_REQ.
  - One-hot tag i enters a ROM_LAT-deep shift register.
- With no transfer: rom_address holds its value, the pointer is unchanged, and a zero tag enters the pipe.
- Response: at posedge t+ROM_LAT, rsp_valid <= tag and rsp_data <= rom_q.
  - rsp_valid is a one-cycle pulse per transfer.
  - rsp_data holds its last value when rsp_valid=0.
- Throughput: one transfer per cycle. Back-to-back transfers from different requesters produce back-to-back responses in issue order.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- hold asserted:
  - Grants stop in the same cycle.
  - In-flight responses still complete.
  - The pointer is frozen.
- A requester that drops req_valid without a transfer loses nothing; no state is kept per request.
- Reset asserted mid-operation: in-flight responses are discarded and no rsp_valid is produced for them.
- req_addr[i] is sampled only at the transfer edge; it may change freely afterward.

Optional Feature:
- Macro SPRITE_ARB_LOCK_EN adds an input port req_lock (N_REQ bits).
- With the macro:
  - If granted requester i transfers with req_lock[i]=1, it keeps the grant (the pointer does not advance) for as long as req_valid[i] & req_lock[i] stay high and hold=0.
  - This lets a sprite fetch a full row burst.
  - The lock releases on the first transfer with req_lock[i]=0, or on any cycle where req_valid[i]=0; then normal RR resumes from i+1.
  - hold suspends a lock without releasing it.
- Without the macro: the port is absent and behaviour is pure round robin.

Test Plan:
1. Reset with all req_valid=1 → req_ready=0, rom_address=0, rsp_valid=0 until reset_n rises. First grant goes to requester 0.
2. All 4 requesters valid for 8 cycles, with addresses 10, 20, 30, 40 and a ROM model (negedge, q=addr[4:0]) → grants 0,1,2,3,0,1,2,3. rsp_valid one-hot sequence matches, delayed by ROM_LAT+1 cycles, with rsp_data = 10, 20, 30, 8 (40 truncated to 5 bits).
3. Only requester 2 valid, addr 0x1FF → req_ready=4'b0100 every cycle, rom_address=0x1FF, rsp_data=0x1F each cycle.
4. hold=1 for 3 cycles during a 4-requester stream → req_ready=0 for those cycles. Already-accepted responses still arrive. After hold drops, the rotation resumes at the next index in sequence.
5. reset_n pulsed low one cycle after a transfer → no rsp_valid for that transfer; all outputs are 0 immediately, asynchronously.
6. With SPRITE_ARB_LOCK_EN: requester 1 locks for 5 transfers while 0, 2 and 3 are valid → req_ready=4'b0010 for 5 cycles, then grants go to 2, 3, 0.
